// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory line responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2,
    TURN = 2'd3
  } dmem_state_e;

  localparam int DMEM_LINE_W  = 256;
  localparam int DMEM_DEPTH   = 512;
  localparam int DMEM_LATENCY = 10;
  localparam int DMEM_OFFS_W  = 5;   // byte offset within a 32-byte line

endpackage

// File: rtl/dmem_line_array.sv
// Line storage: synchronous write, combinational read, zero at time 0, never cleared by reset.
module dmem_line_array #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH] = '{default: '0};

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_line_responder.sv
// Fixed-latency line memory answering data-cache read / write-back requests with a one-cycle ack.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int LINE_W  = DMEM_LINE_W,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              mem_ack_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              busy_o,
  output logic              protocol_err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              arr_we;
  logic [LINE_W-1:0] arr_rdata;

  // Upper address bits alias; byte offset is irrelevant for whole-line transfers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr_i[31:DMEM_OFFS_W+IDX_W], mem_addr_i[DMEM_OFFS_W-1:0]};

  dmem_line_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    arr_we  = 1'b0;
    unique case (state_q)
      // The edge closing TURN is the first IDLE sampling point, so a held
      // enable is accepted there and back-to-back requests lose no cycle.
      IDLE, TURN: begin
        state_d = IDLE;
        if (mem_enable_i) begin
          state_d = BUSY;
          idx_d   = mem_addr_i[DMEM_OFFS_W +: IDX_W];
          wr_d    = mem_write_i;
          wdata_d = mem_data_i;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (!mem_enable_i) err_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ACK;
          if (wr_q) arr_we = 1'b1;
          else      rdata_d = arr_rdata;
        end
      end
      ACK: state_d = TURN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_ack_o      = (state_q == ACK);
  assign busy_o         = (state_q == BUSY) || (state_q == ACK);
  assign mem_data_o     = rdata_q;
  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed + randomized bench for dmem_line_responder against a line-array reference model.
module tb_dmem_line_responder;

  localparam int LINE_W = 256;
  localparam int DEPTH  = 512;
  localparam int LAT    = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en  = 1'b0;
  logic              we  = 1'b0;
  logic [31:0]       addr = '0;
  logic [LINE_W-1:0] din  = '0;
  logic              ack;
  logic [LINE_W-1:0] dout;
  logic              busy;
  logic              perr;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  logic [LINE_W-1:0] ref_mem [DEPTH];

  dmem_line_responder #(
    .LINE_W  (LINE_W),
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_enable_i   (en),
    .mem_write_i    (we),
    .mem_addr_i     (addr),
    .mem_data_i     (din),
    .mem_ack_o      (ack),
    .mem_data_o     (dout),
    .busy_o         (busy),
    .protocol_err_o (perr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) % DEPTH);
  endfunction

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called at a negedge; issues one request and returns at the negedge of the
  // turnaround cycle. drop_at >= 0 deasserts enable in that BUSY cycle.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [LINE_W-1:0] d,
                      input bit keep, input int drop_at, output int ack_cyc);
    int ack_k;
    logic [LINE_W-1:0] exp_rd;
    exp_rd = ref_mem[line_of(a)];
    en = 1'b1; we = wr; addr = a; din = d;
    ack_k = -1;
    ack_cyc = -1;
    for (int k = 0; k < LAT + 20 && ack_k < 0; k++) begin
      @(negedge clk);
      if (k == 0) chk("busy_after_accept", busy, 1);
      if (k == drop_at) begin
        chk("perr_before_drop", perr, 0);
        en = 1'b0;
      end
      if (drop_at >= 0 && k == drop_at + 1) chk("perr_set", perr, 1);
      if (ack) begin
        ack_k = k;
        ack_cyc = cyc;
      end
    end
    chk("ack_latency", LINE_W'(ack_k), LINE_W'(LAT));
    if (wr) ref_mem[line_of(a)] = d;
    else if (ack_k >= 0) chk("read_data", dout, exp_rd);
    @(negedge clk);
    chk("ack_one_cycle", ack, 0);
    chk("busy_low_turn", busy, 0);
    if (!wr) chk("data_held", dout, exp_rd);
    if (!keep) en = 1'b0;
  endtask

  initial begin
    int c1, c2, seen;
    logic [LINE_W-1:0] v, old_line;
    logic [31:0] a;
    bit w;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", perr, 0);
    chk("rst_data", dout, '0);
    rst = 1'b1;

    // Idle with enable low: no ack
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack) seen++;
    end
    chk("idle_no_ack", LINE_W'(seen), '0);

    // Preload lines 0..3 with random data, then read line 2
    for (int i = 0; i < 4; i++) xfer(1'b1, 32'(i * 32), rnd_line(), 1'b0, -1, c1);
    @(negedge clk);
    xfer(1'b0, 32'h0000_0040, '0, 1'b0, -1, c1);

    // Write-back then refill read, enable held across turnaround
    @(negedge clk);
    v = {(LINE_W / 8){8'hA5}};
    xfer(1'b1, 32'h0000_03E0, v, 1'b1, -1, c1);
    xfer(1'b0, 32'h0000_03E0, '0, 1'b0, -1, c2);
    chk("b2b_ack_spacing", LINE_W'(c2 - c1), LINE_W'(LAT + 2));
    chk("b2b_read_A5", dout, v);

    // Aliasing: 0x4020 and 0x0020 both map to line 1
    @(negedge clk);
    v = rnd_line();
    xfer(1'b1, 32'h0000_4020, v, 1'b0, -1, c1);
    @(negedge clk);
    xfer(1'b0, 32'h0000_0020, '0, 1'b0, -1, c1);
    chk("alias_data", dout, v);

    // Random traffic over a few lines with random upper/offset bits
    for (int n = 0; n < 10; n++) begin
      a = $urandom;
      a[13:5] = 9'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      xfer(w, a, rnd_line(), 1'($urandom_range(0, 1)), -1, c1);
      if ($urandom_range(0, 1) == 1) begin
        en = 1'b0;
        @(negedge clk);
      end
    end
    en = 1'b0;
    @(negedge clk);

    // Reset during a write: line must keep its old contents
    a = 32'h0000_00A0;
    old_line = ref_mem[line_of(a)];
    en = 1'b1; we = 1'b1; addr = a; din = ~old_line;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_data", dout, '0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (ack || busy) seen++;
    end
    chk("midrst_no_ack", LINE_W'(seen), '0);
    xfer(1'b0, a, '0, 1'b0, -1, c1);
    chk("midrst_line_kept", dout, old_line);

    // Protocol error: enable dropped three cycles into a read
    @(negedge clk);
    xfer(1'b0, 32'h0000_0060, '0, 1'b0, 3, c1);
    repeat (5) @(negedge clk);
    chk("perr_sticky", perr, 1);
    rst = 1'b0;
    #1;
    chk("perr_cleared", perr, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dmem_line_responder.md
# dmem_line_responder

Responder side of the data-cache ↔ data-memory line interface: a 256-bit-line main-memory model with configurable access latency.
- Accepts read or write-back requests from the data cache controller and completes each after a fixed number of cycles with a one-cycle acknowledge.
- Sits below the data cache in the CPU's memory hierarchy and replaces the ad-hoc testbench memory.
- Serves both simulation and any FPGA build that needs a deterministic, slow backing store.

## Interface
- LINE_W, 256, line width in bits (fixed by cache line size)
- DEPTH, 512, number of lines; power of two
- LATENCY, 10, cycles from request acceptance to ack; ≥1
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- mem_enable_i  in  1  request valid; held high by initiator until ack seen
- mem_write_i  in  1  1 = write line, 0 = read line
- mem_addr_i  in  32  byte address; bits [4:0] ignored, line index = addr[5 +: log2(DEPTH)], upper bits ignored (aliasing)
- mem_data_i  in  LINE_W  write data
- mem_ack_o  out  1  completion strobe, exactly one cycle per request
- mem_data_o  out  LINE_W  read data, valid while mem_ack_o high, held afterwards
- busy_o  out  1  request in progress (BUSY or ACK state)
- protocol_err_o  out  1  sticky: mem_enable_i dropped while BUSY

## Operation
- States: IDLE, BUSY, ACK, TURN.
- IDLE: mem_enable_i=1 at an edge → latch index, write flag and write data; load cnt=LATENCY-1; → BUSY. Otherwise stay.
- BUSY: cnt≠0 → cnt−1. cnt=0 → ACK. On that same edge:
  - write: array[index] ← latched data;
  - read: mem_data_o ← array[index].
- ACK: mem_ack_o=1 for this cycle only; → TURN unconditionally.
- TURN: one turnaround cycle, ack low, request inputs ignored; → IDLE. The initiator samples ack on the opposite clock phase and needs one cycle to deassert enable or switch direction.
- Back-to-back: enable held high across TURN starts a new request at the first IDLE edge. Example: write-back followed by refill read with write dropped and enable kept high.
- Inputs changing during BUSY/ACK/TURN are ignored; the latched request is authoritative.
- mem_enable_i low in BUSY → protocol_err_o set (sticky until reset); the request still completes normally.
- Reset (any time, including mid-request):
  - state IDLE, cnt 0, mem_ack_o 0, mem_data_o 0, busy_o 0, protocol_err_o 0;
  - a pending write not yet committed is dropped;
  - array contents are not cleared.
- Array initial contents: zero at time 0 (simulation initializer); no reset clear.

## Timing
- Request sampled at edge t0 → mem_ack_o high in cycle [t0+LATENCY, t0+LATENCY+1).
- Earliest next acceptance: edge t0+LATENCY+2.
- Write visible to a subsequent read of the same line: yes, committed before that read's ack.
- LATENCY=1: BUSY lasts one cycle; ack at t0+1.
- Counter width: $clog2(LATENCY) bits, minimum 1.
- busy_o is high from edge t0 through the ACK cycle; low in TURN and IDLE.

## Structure
- Shared package `dmem_pkg`:
  - state enum (IDLE=2'd0, BUSY=2'd1, ACK=2'd2, TURN=2'd3);
  - LINE_W, default DEPTH, default LATENCY;
  - line-offset width constant (5).
- Sub-module `dmem_line_array`: DEPTH×LINE_W storage with synchronous write port and combinational read. The top-level block holds the FSM, counter, request latches and output register.

## Test plan
- Reset then idle: rst_i low mid-simulation → all outputs 0; with enable low for 20 cycles, ack never rises.
- Read latency: LATENCY=10, read addr 0x0000_0040 at edge t0 → ack high only in cycle t0+10; mem_data_o = preloaded line 2; ack low at t0+11.
- Write then read: write 0xA5…A5 to 0x0000_03E0 with enable held through TURN, then switch to read the same address → second ack returns 0xA5…A5; second ack at t0+22 (10 + ack + turn + 10).
- Aliasing: write to 0x0000_4020 (DEPTH=512), read 0x0000_0020 → same data.
- Reset mid-write: write started, rst_i pulsed low at t0+5 → line unchanged; FSM IDLE; no ack.
- Protocol error: drop enable at t0+3 of a read → protocol_err_o=1 from t0+4; ack still at t0+10; flag stays 1 until reset.
